// File: rtl/pulse_rx_pkg.sv
// Shared state encoding and default parameters for the pulse-burst receiver.
// The bench imports this package to stay in step with the RTL defaults.
package pulse_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        COUNT  = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam int CNT_W_DEF       = 8;
    localparam int TIME_W_DEF      = 16;
    localparam int TIMEOUT_DEF     = 64;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level with one-cycle rise/fall strobes.
// Reused for any asynchronous input that needs edge detection in the clk domain.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic p_s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_p_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_p_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_p_d  <= r_sync[SYNC_STAGES-1];
        end
    end

    assign p_s  = r_sync[SYNC_STAGES-1];
    assign rise = p_s & ~r_p_d;
    assign fall = ~p_s & r_p_d;

endmodule

// File: rtl/pulse_burst_receiver.sv
// Counts the pulses of one burst on an asynchronous line, measures the last pulse's
// high width and period, and hands the result out through a valid/ready report.
//
// state  | meaning
// IDLE   | waiting for enab; report registers and timers cleared
// ARMED  | enabled, waiting for the first rising edge
// COUNT  | counting edges and timing pulses until quiet timeout or enab drop
// REPORT | burst_valid high, results frozen until burst_ready
module pulse_burst_receiver
    import pulse_rx_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIME_W      = TIME_W_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enab,
    input  logic              pulses,
    input  logic              burst_ready,
    output logic              burst_valid,
    output logic [CNT_W-1:0]  pulse_count,
    output logic [TIME_W-1:0] last_high,
    output logic [TIME_W-1:0] last_period,
    output logic              overflow,
    output logic              busy
);

    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [TIME_W-1:0] TIME_MAX  = '1;
    localparam logic [TIME_W-1:0] QUIET_END = TIME_W'(TIMEOUT - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_count;
    logic [TIME_W-1:0] r_per_tmr;
    logic [TIME_W-1:0] r_high_tmr;
    logic [TIME_W-1:0] r_quiet_tmr;
    logic [TIME_W-1:0] r_last_high;
    logic [TIME_W-1:0] r_last_period;
    logic              r_ovf;
    logic              r_valid;
    logic              r_busy;

    logic              w_p_s;
    logic              w_rise;
    logic              w_fall;
    logic [TIME_W-1:0] w_quiet_cur;
    logic              w_end;
    logic              w_per_sat;
    logic              w_high_sat;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (pulses),
        .p_s     (w_p_s),
        .rise    (w_rise),
        .fall    (w_fall)
    );

    // Quiet count includes the current low cycle, so the timeout report lands
    // exactly TIMEOUT cycles after the fall seen at p_s.
    assign w_quiet_cur = (w_rise | w_fall) ? '0 : r_quiet_tmr;
    assign w_end       = ~w_p_s & ((w_quiet_cur == QUIET_END) | ~enab);
    assign w_per_sat   = (r_per_tmr == TIME_MAX);
    assign w_high_sat  = (r_high_tmr == TIME_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_per_tmr     <= '0;
            r_high_tmr    <= '0;
            r_quiet_tmr   <= '0;
            r_last_high   <= '0;
            r_last_period <= '0;
            r_ovf         <= 1'b0;
            r_valid       <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_count       <= '0;
                    r_per_tmr     <= '0;
                    r_high_tmr    <= '0;
                    r_quiet_tmr   <= '0;
                    r_last_high   <= '0;
                    r_last_period <= '0;
                    r_ovf         <= 1'b0;
                    if (enab) begin
                        r_state <= ARMED;
                        r_busy  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (w_rise) begin
                        r_state     <= COUNT;
                        r_count     <= CNT_W'(1);
                        r_per_tmr   <= '0;
                        r_high_tmr  <= '0;
                        r_quiet_tmr <= '0;
                    end else if (!enab) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                COUNT: begin
                    if (w_rise) begin
                        if (r_count == CNT_MAX) r_ovf <= 1'b1;
                        else                    r_count <= r_count + CNT_W'(1);
                        r_last_period <= w_per_sat ? TIME_MAX : r_per_tmr + TIME_W'(1);
                        r_per_tmr     <= '0;
                        r_high_tmr    <= '0;
                    end else begin
                        if (w_per_sat) r_ovf <= 1'b1;
                        else           r_per_tmr <= r_per_tmr + TIME_W'(1);
                        if (w_p_s) begin
                            if (w_high_sat) r_ovf <= 1'b1;
                            else            r_high_tmr <= r_high_tmr + TIME_W'(1);
                        end
                    end
                    if (w_fall) begin
                        r_last_high <= w_high_sat ? TIME_MAX : r_high_tmr + TIME_W'(1);
                        r_high_tmr  <= '0;
                    end
                    r_quiet_tmr <= w_p_s ? '0 : w_quiet_cur + TIME_W'(1);
                    if (w_end) begin
                        r_state <= REPORT;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                REPORT: begin
                    if (burst_ready) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign burst_valid = r_valid;
    assign pulse_count = r_count;
    assign last_high   = r_last_high;
    assign last_period = r_last_period;
    assign overflow    = r_ovf;
    assign busy        = r_busy;

endmodule

// File: tb/tb_pulse_burst_receiver.sv
// Directed bench for pulse_burst_receiver: default instance plus a 4-bit count
// instance sharing the same stimulus to exercise count saturation.
module tb_pulse_burst_receiver;
    import pulse_rx_pkg::*;

    localparam int LAT_TO  = SYNC_STAGES_DEF + TIMEOUT_DEF;
    localparam int LAT_EN  = SYNC_STAGES_DEF + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enab = 1'b0;
    logic        pulses = 1'b0;
    logic        burst_ready = 1'b0;

    logic        valid8, ovf8, busy8;
    logic [7:0]  cnt8;
    logic [15:0] high8, per8;
    logic        valid4, ovf4, busy4;
    logic [3:0]  cnt4;
    logic [15:0] high4, per4;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    pulse_burst_receiver dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .enab        (enab),
        .pulses      (pulses),
        .burst_ready (burst_ready),
        .burst_valid (valid8),
        .pulse_count (cnt8),
        .last_high   (high8),
        .last_period (per8),
        .overflow    (ovf8),
        .busy        (busy8)
    );

    pulse_burst_receiver #(.CNT_W(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .enab        (enab),
        .pulses      (pulses),
        .burst_ready (burst_ready),
        .burst_valid (valid4),
        .pulse_count (cnt4),
        .last_high   (high4),
        .last_period (per4),
        .overflow    (ovf4),
        .busy        (busy4)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int hi, input int lo);
        pulses = 1'b1;
        cyc(hi);
        pulses = 1'b0;
        cyc(lo);
    endtask

    // n pulses high hi / low 20; line left low right after the last fall
    task automatic burst(input int n, input int hi);
        for (int i = 0; i < n - 1; i++) pulse(hi, 20);
        pulses = 1'b1;
        cyc(hi);
        pulses = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (!valid8 && n < 300) begin
            cyc(1);
            n++;
        end
        chk(tag, 32'(n), 32'(exp_lat));
    endtask

    task automatic handshake();
        burst_ready = 1'b1;
        cyc(1);
        chk("valid_drop", 32'(valid8), 32'd0);
        burst_ready = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(2);
        chk("rst_valid", 32'(valid8), 32'd0);
        chk("rst_count", 32'(cnt8), 32'd0);
        chk("rst_high", 32'(high8), 32'd0);
        chk("rst_period", 32'(per8), 32'd0);
        chk("rst_ovf", 32'(ovf8), 32'd0);
        chk("rst_busy", 32'(busy8), 32'd0);
        rst_n = 1'b1;
        cyc(1);
        enab = 1'b1;
        cyc(1);
        chk("armed_busy", 32'(busy8), 32'd1);

        // ten pulses, timeout exit
        burst(10, 10);
        wait_valid("lat_timeout", LAT_TO);
        chk("b10_count", 32'(cnt8), 32'd10);
        chk("b10_high", 32'(high8), 32'd10);
        chk("b10_period", 32'(per8), 32'd30);
        chk("b10_ovf", 32'(ovf8), 32'd0);
        chk("b10_busy", 32'(busy8), 32'd0);
        handshake();
        cyc(1);
        chk("rearm_busy", 32'(busy8), 32'd1);

        // single short pulse
        burst(1, 5);
        wait_valid("lat_single", LAT_TO);
        chk("b1_count", 32'(cnt8), 32'd1);
        chk("b1_high", 32'(high8), 32'd5);
        chk("b1_period", 32'(per8), 32'd0);
        handshake();
        cyc(1);

        // twenty pulses: 4-bit instance saturates
        burst(20, 10);
        wait_valid("lat_b20", LAT_TO);
        chk("b20_count8", 32'(cnt8), 32'd20);
        chk("b20_ovf8", 32'(ovf8), 32'd0);
        chk("b20_valid4", 32'(valid4), 32'd1);
        chk("b20_count4", 32'(cnt4), 32'd15);
        chk("b20_ovf4", 32'(ovf4), 32'd1);
        handshake();
        cyc(1);

        // enab dropped while pulse 3 is high
        pulse(10, 20);
        pulse(10, 20);
        pulses = 1'b1;
        cyc(4);
        enab = 1'b0;
        cyc(6);
        pulses = 1'b0;
        chk("drop_wait_valid", 32'(valid8), 32'd0);
        chk("drop_wait_busy", 32'(busy8), 32'd1);
        wait_valid("lat_enab_drop", LAT_EN);
        chk("drop_count", 32'(cnt8), 32'd3);
        chk("drop_high", 32'(high8), 32'd10);
        chk("drop_period", 32'(per8), 32'd30);
        handshake();
        cyc(2);
        chk("drop_idle_busy", 32'(busy8), 32'd0);

        // report held while ready low and extra pulses arrive
        enab = 1'b1;
        cyc(1);
        burst(2, 10);
        wait_valid("lat_hold", LAT_TO);
        pulse(10, 20);
        pulse(10, 10);
        chk("hold_valid", 32'(valid8), 32'd1);
        chk("hold_count", 32'(cnt8), 32'd2);
        chk("hold_high", 32'(high8), 32'd10);
        chk("hold_period", 32'(per8), 32'd30);
        burst_ready = 1'b1;
        cyc(1);
        burst_ready = 1'b0;
        chk("hold_drop_valid", 32'(valid8), 32'd0);
        chk("hold_idle_busy", 32'(busy8), 32'd0);
        cyc(1);
        chk("hold_armed_busy", 32'(busy8), 32'd1);

        // asynchronous reset during COUNT
        pulse(10, 20);
        pulse(10, 20);
        pulses = 1'b1;
        cyc(3);
        chk("pre_rst_count", 32'(cnt8), 32'd3);
        chk("pre_rst_busy", 32'(busy8), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(cnt8), 32'd0);
        chk("arst_high", 32'(high8), 32'd0);
        chk("arst_period", 32'(per8), 32'd0);
        chk("arst_busy", 32'(busy8), 32'd0);
        pulses = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        chk("post_rst_busy", 32'(busy8), 32'd1);

        // ready held high: report visible for one cycle
        burst_ready = 1'b1;
        burst(1, 5);
        wait_valid("lat_post_rst", LAT_TO);
        chk("post_rst_count", 32'(cnt8), 32'd1);
        chk("post_rst_high", 32'(high8), 32'd5);
        chk("post_rst_period", 32'(per8), 32'd0);
        cyc(1);
        chk("ready_held_valid", 32'(valid8), 32'd0);
        burst_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
